counter_cmd_scheduler: RTL and testbench

- Shares one WIDTH-bit counter between three command requesters:
  - host "up" trigger,
  - host "down" trigger,
  - internal prescaled auto-tick.
- A host "clear" command takes priority over all of them.
- Command pulses are latched as pending requests and granted one per cycle. Clear always wins; the other three are granted round-robin.
- Sits between the host trigger-in endpoint (sys_clk domain) and the count/trigger-out endpoints. It replaces ad-hoc priority if/else chains, which silently lose simultaneous commands.

---
 rtl/counter_cmd_scheduler.sv | 141 ++++++++++++++
 tb/tb_counter_cmd_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_cmd_scheduler.sv
// Shared counter: latches clear/up/down/auto-tick requests and grants one per cycle (clear first, others round-robin).
// A request sampled at edge k is applied at edge k+1; enable=0 holds grants while requests keep latching.
module counter_cmd_scheduler #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 24,
  parameter logic [DIV_W-1:0] DIV_RELOAD = 24'h100000
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             cmd_clr,
  input  logic             cmd_up,
  input  logic             cmd_down,
  input  logic             autocount,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             wrap_up,
  output logic             wrap_down,
  output logic [1:0]       grant,
  output logic [3:0]       pending,
  output logic [7:0]       drop_count
);

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_UP   = 2'd1;
  localparam logic [1:0] GNT_DOWN = 2'd2;
  localparam logic [1:0] GNT_TICK = 2'd3;

  logic [WIDTH-1:0] count_q, count_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       pend_q, pend_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       rr_q, rr_d;
  logic [7:0]       drop_q, drop_d;
  logic             wrap_up_q, wrap_up_d;
  logic             wrap_down_q, wrap_down_d;

  logic             tick_req;
  logic [3:0]       req;
  logic [3:0]       consume;
  logic [3:0]       drops;
  logic [1:0]       sel;
  logic             do_clr;
  logic [8:0]       drop_sum;

  always_comb begin
    tick_req    = autocount && (div_q == '0);
    div_d       = (div_q == '0) ? DIV_RELOAD : div_q - 1'b1;
    req         = {tick_req, cmd_down, cmd_up, cmd_clr};
    sel         = GNT_NONE;
    consume     = 4'b0000;
    do_clr      = 1'b0;
    count_d     = count_q;
    rr_d        = rr_q;
    wrap_up_d   = 1'b0;
    wrap_down_d = 1'b0;

    if (enable) begin
      if (pend_q[0]) begin
        do_clr  = 1'b1;
        consume = 4'b1111;
      end else begin
        // Search starts at the source after the last one granted.
        case (rr_q)
          GNT_UP: begin
            if (pend_q[2])      sel = GNT_DOWN;
            else if (pend_q[3]) sel = GNT_TICK;
            else if (pend_q[1]) sel = GNT_UP;
          end
          GNT_DOWN: begin
            if (pend_q[3])      sel = GNT_TICK;
            else if (pend_q[1]) sel = GNT_UP;
            else if (pend_q[2]) sel = GNT_DOWN;
          end
          default: begin
            if (pend_q[1])      sel = GNT_UP;
            else if (pend_q[2]) sel = GNT_DOWN;
            else if (pend_q[3]) sel = GNT_TICK;
          end
        endcase
        if (sel != GNT_NONE) begin
          consume[sel] = 1'b1;
          rr_d         = sel;
        end
      end
    end

    if (do_clr) begin
      count_d = '0;
    end else begin
      case (sel)
        GNT_UP, GNT_TICK: begin
          count_d   = count_q + 1'b1;
          wrap_up_d = (count_q == '1);
        end
        GNT_DOWN: begin
          count_d     = count_q - 1'b1;
          wrap_down_d = (count_q == '0);
        end
        default: ;
      endcase
    end
    grant_d = sel;

    // A fresh request landing on a flag that is consumed this cycle is not a drop.
    pend_d   = (pend_q & ~consume) | req;
    drops    = req & pend_q & ~consume;
    drop_sum = {1'b0, drop_q} + {8'b0, drops[0]} + {8'b0, drops[1]}
             + {8'b0, drops[2]} + {8'b0, drops[3]};
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      count_q     <= '0;
      div_q       <= DIV_RELOAD;
      pend_q      <= 4'b0000;
      grant_q     <= GNT_NONE;
      rr_q        <= GNT_TICK;
      drop_q      <= 8'h00;
      wrap_up_q   <= 1'b0;
      wrap_down_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      div_q       <= div_d;
      pend_q      <= pend_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      drop_q      <= drop_d;
      wrap_up_q   <= wrap_up_d;
      wrap_down_q <= wrap_down_d;
    end
  end

  assign count      = count_q;
  assign wrap_up    = wrap_up_q;
  assign wrap_down  = wrap_down_q;
  assign grant      = grant_q;
  assign pending    = pend_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_counter_cmd_scheduler.sv
// Directed bench for counter_cmd_scheduler with a short prescaler (auto-tick every 4 cycles).
module tb_counter_cmd_scheduler;

  logic       sys_clk;
  logic       reset;
  logic       cmd_clr;
  logic       cmd_up;
  logic       cmd_down;
  logic       autocount;
  logic       enable;
  logic [7:0] count;
  logic       wrap_up;
  logic       wrap_down;
  logic [1:0] grant;
  logic [3:0] pending;
  logic [7:0] drop_count;

  int tests_run = 0;
  int tests_failed = 0;

  counter_cmd_scheduler #(
    .WIDTH(8),
    .DIV_W(24),
    .DIV_RELOAD(24'd3)
  ) dut (
    .sys_clk(sys_clk),
    .reset(reset),
    .cmd_clr(cmd_clr),
    .cmd_up(cmd_up),
    .cmd_down(cmd_down),
    .autocount(autocount),
    .enable(enable),
    .count(count),
    .wrap_up(wrap_up),
    .wrap_down(wrap_down),
    .grant(grant),
    .pending(pending),
    .drop_count(drop_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_clr = 1'b0;
    cmd_up = 1'b0;
    cmd_down = 1'b0;
    autocount = 1'b0;
    enable = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_count", count, 0);
    check("rst_pending", pending, 0);
    check("rst_grant", grant, 0);
    check("rst_wrap_up", wrap_up, 0);
    check("rst_wrap_down", wrap_down, 0);
    check("rst_drop", drop_count, 0);

    // Single up pulse: pending after edge k, count/grant after edge k+1.
    cmd_up = 1'b1;
    step();
    cmd_up = 1'b0;
    check("up_pending", pending, 4'b0010);
    check("up_count_early", count, 0);
    step();
    check("up_count", count, 1);
    check("up_grant", grant, 1);
    check("up_pending_clr", pending, 0);
    step();
    check("up_grant_pulse", grant, 0);

    // Up, down and tick all pending from a fresh pointer: grants 1,2,3.
    do_reset();
    enable = 1'b0;
    autocount = 1'b1;
    cmd_up = 1'b1;
    cmd_down = 1'b1;
    step();
    cmd_up = 1'b0;
    cmd_down = 1'b0;
    check("rr_pend_ud", pending, 4'b0110);
    step();
    step();
    step();
    check("rr_pend_all", pending, 4'b1110);
    check("rr_frozen_count", count, 0);
    autocount = 1'b0;
    enable = 1'b1;
    step();
    check("rr_g1", grant, 1);
    check("rr_c1", count, 1);
    step();
    check("rr_g2", grant, 2);
    check("rr_c2", count, 0);
    step();
    check("rr_g3", grant, 3);
    check("rr_c3", count, 1);
    check("rr_pend_done", pending, 0);

    // Wrap in both directions.
    do_reset();
    cmd_down = 1'b1;
    step();
    cmd_down = 1'b0;
    step();
    check("wd_count", count, 8'hFF);
    check("wd_pulse", wrap_down, 1);
    check("wd_grant", grant, 2);
    check("wd_no_wu", wrap_up, 0);
    step();
    check("wd_one_cycle", wrap_down, 0);
    cmd_up = 1'b1;
    step();
    cmd_up = 1'b0;
    step();
    check("wu_count", count, 0);
    check("wu_pulse", wrap_up, 1);
    step();
    check("wu_one_cycle", wrap_up, 0);

    // Frozen grants: repeated up pulses drop into an already-pending flag.
    enable = 1'b0;
    cmd_up = 1'b1;
    step();
    step();
    step();
    cmd_up = 1'b0;
    check("frz_pending", pending, 4'b0010);
    check("frz_drop", drop_count, 2);
    check("frz_count", count, 0);
    enable = 1'b1;
    step();
    check("frz_release", count, 1);
    step();
    check("frz_once", count, 1);

    // Two drops in one cycle add two.
    enable = 1'b0;
    cmd_up = 1'b1;
    cmd_down = 1'b1;
    step();
    step();
    cmd_up = 1'b0;
    cmd_down = 1'b0;
    check("dbl_drop", drop_count, 4);
    check("dbl_pending", pending, 4'b0110);

    // Clear wipes pending up/down; a same-cycle down still latches.
    cmd_clr = 1'b1;
    step();
    cmd_clr = 1'b0;
    check("clr_pending", pending, 4'b0111);
    enable = 1'b1;
    cmd_down = 1'b1;
    step();
    cmd_down = 1'b0;
    check("clr_count", count, 0);
    check("clr_grant", grant, 0);
    check("clr_no_wu", wrap_up, 0);
    check("clr_no_wd", wrap_down, 0);
    check("clr_relatch", pending, 4'b0100);
    step();
    check("clr_then_down", count, 8'hFF);
    check("clr_then_wd", wrap_down, 1);

    // Drop counter saturates.
    enable = 1'b0;
    cmd_up = 1'b1;
    repeat (260) step();
    cmd_up = 1'b0;
    check("sat_drop", drop_count, 8'hFF);
    check("sat_count", count, 8'hFF);

    // Auto-tick: one increment every 4 cycles after reset.
    do_reset();
    check("tick_rst_drop", drop_count, 0);
    check("tick_rst_pend", pending, 0);
    autocount = 1'b1;
    repeat (4) step();
    check("tick_pend", pending, 4'b1000);
    check("tick_c0", count, 0);
    step();
    check("tick_c1", count, 1);
    check("tick_grant", grant, 3);
    repeat (3) step();
    check("tick_c1_hold", count, 1);
    step();
    check("tick_c2", count, 2);
    repeat (11) step();
    check("tick_c4", count, 4);
    step();
    check("tick_c5", count, 5);

    // Reset mid-run beats same-cycle requests and restarts the prescaler.
    reset = 1'b1;
    cmd_up = 1'b1;
    cmd_clr = 1'b1;
    step();
    reset = 1'b0;
    cmd_up = 1'b0;
    cmd_clr = 1'b0;
    check("mid_rst_count", count, 0);
    check("mid_rst_pend", pending, 0);
    check("mid_rst_grant", grant, 0);
    check("mid_rst_drop", drop_count, 0);
    repeat (4) step();
    check("mid_rst_c0", count, 0);
    step();
    check("mid_rst_c1", count, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
